// File: rtl/tff_seq_ctrl.sv
// Sequencing controller for a bank of T flip-flops: drives the per-bit toggle
// vector so the bank walks a selectable sequence for a programmed step count.
module tff_seq_ctrl #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             hold_i,
  input  logic             abort_i,
  input  logic [1:0]       mode_i,
  input  logic [LEN_W-1:0] len_i,
  output logic [WIDTH-1:0] t_out_o,
  output logic [WIDTH-1:0] q_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             wrap_o
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [1:0]        mode_q, mode_d;
  logic              wrap_q, wrap_d;

  logic [WIDTH-1:0]  step_t;
  logic [WIDTH-1:0]  bin_cur;
  logic [WIDTH-1:0]  bin_nxt;
  logic [WIDTH-1:0]  gray_nxt;

  // In Gray mode the bank holds a Gray code; bit i of its binary value is the
  // XOR of bank bits i and above.
  always_comb begin
    bin_cur = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      bin_cur[i] = ^(q_q >> i);
    end
    bin_nxt  = bin_cur + WIDTH'(1);
    gray_nxt = bin_nxt ^ (bin_nxt >> 1);

    step_t = '0;
    case (mode_q)
      2'b00: step_t = q_q ^ (q_q + WIDTH'(1));
      2'b01: step_t = q_q ^ (q_q - WIDTH'(1));
      2'b10: step_t = q_q ^ gray_nxt;
      2'b11: begin
        step_t[0] = ~q_q[1];
        step_t[1] = 1'b1;
        step_t[2] = q_q[1];
      end
      default: step_t = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    wrap_d  = 1'b0;
    t_out_o = '0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          t_out_o = q_q;
          rem_d   = len_i;
          mode_d  = mode_i;
          state_d = (len_i != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (!hold_i) begin
          t_out_o = step_t;
          rem_d   = rem_q - LEN_W'(1);
          wrap_d  = ((q_q ^ step_t) == '0);
          if (rem_q == LEN_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    q_d = q_q ^ t_out_o;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      q_q     <= '0;
      rem_q   <= '0;
      mode_q  <= 2'b00;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      wrap_q  <= wrap_d;
    end
  end

  assign q_o    = q_q;
  assign busy_o = (state_q == RUN);
  assign done_o = (state_q == DONE);
  assign wrap_o = wrap_q;

endmodule
